// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-master round-robin arbiter/sequencer in front of the
//            lomem / pmon / himem memory container.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned LOMEM_SIZE = 65536,
    parameter logic [31:0] PMON_BASE  = 32'h0000_F000,
    parameter logic [31:0] HIMEM_BASE = 32'h0001_0000,
    parameter int unsigned HIMEM_SIZE = 65536
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0_req,
    input  logic             m0_wen,
    input  logic [31:0]      m0_addr,
    input  logic [WIDTH-1:0] m0_wdata,
    output logic             m0_ack,
    output logic [WIDTH-1:0] m0_rdata,
    output logic             m0_err,
    input  logic             m1_req,
    input  logic             m1_wen,
    input  logic [31:0]      m1_addr,
    input  logic [WIDTH-1:0] m1_wdata,
    output logic             m1_ack,
    output logic [WIDTH-1:0] m1_rdata,
    output logic             m1_err,
    output logic [31:0]      mem_addr,
    output logic [WIDTH-1:0] mem_din,
    output logic             mem_wen,
    output logic             cs_lomem,
    output logic             cs_pmon,
    output logic             cs_himem,
    input  logic [WIDTH-1:0] mem_dout
);

    // Region limits are widened to 33 bits so base+size can never wrap.
    localparam logic [32:0] c_PMON_LO = {1'b0, PMON_BASE};
    localparam logic [32:0] c_PMON_HI = {1'b0, PMON_BASE} + 33'd4096;
    localparam logic [32:0] c_LO_END  = 33'(LOMEM_SIZE);
    localparam logic [32:0] c_HIMEM_LO = {1'b0, HIMEM_BASE};
    localparam logic [32:0] c_HIMEM_HI = {1'b0, HIMEM_BASE} + 33'(HIMEM_SIZE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_rr;
    logic               r_gnt;
    logic [31:0]        r_addr;
    logic [WIDTH-1:0]   r_wdata;
    logic               r_wen;
    logic [2:0]         r_cs;      // {lomem, pmon, himem}
    logic               r_err;

    logic               w_grant;
    logic               w_gnt_id;
    logic [31:0]        w_req_addr;
    logic [32:0]        w_a33;
    logic [2:0]         w_cs;
    logic               w_err;
    logic               w_rd_ok;

    assign w_req_addr = w_gnt_id ? m1_addr : m0_addr;
    assign w_a33      = {1'b0, w_req_addr};

    // pmon overrides lomem, lomem overrides himem; anything else is an error.
    always_comb begin
        w_cs  = 3'b000;
        w_err = 1'b0;
        if (w_a33 >= c_PMON_LO && w_a33 < c_PMON_HI) begin
            w_cs = 3'b010;
        end else if (w_a33 < c_LO_END) begin
            w_cs = 3'b100;
        end else if (HIMEM_SIZE != 0 && w_a33 >= c_HIMEM_LO && w_a33 < c_HIMEM_HI) begin
            w_cs = 3'b001;
        end else begin
            w_err = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_rr    <= 1'b1;
            r_gnt   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wen   <= 1'b0;
            r_cs    <= 3'b000;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_rr    <= w_gnt_id;
                r_gnt   <= w_gnt_id;
                r_addr  <= w_req_addr;
                r_wdata <= w_gnt_id ? m1_wdata : m0_wdata;
                r_wen   <= w_gnt_id ? m1_wen : m0_wen;
                r_cs    <= w_cs;
                r_err   <= w_err;
            end
        end
    end

    assign w_rd_ok = ~r_wen & ~r_err;

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_gnt_id    = 1'b0;
        mem_addr    = '0;
        mem_din     = '0;
        mem_wen     = 1'b0;
        cs_lomem    = 1'b0;
        cs_pmon     = 1'b0;
        cs_himem    = 1'b0;
        m0_ack      = 1'b0;
        m0_err      = 1'b0;
        m0_rdata    = '0;
        m1_ack      = 1'b0;
        m1_err      = 1'b0;
        m1_rdata    = '0;
        case (r_state)
            S_IDLE: begin
                if (m0_req && m1_req) begin
                    w_grant  = 1'b1;
                    w_gnt_id = ~r_rr;
                end else if (m0_req) begin
                    w_grant  = 1'b1;
                    w_gnt_id = 1'b0;
                end else if (m1_req) begin
                    w_grant  = 1'b1;
                    w_gnt_id = 1'b1;
                end
                if (w_grant) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_addr    = r_addr;
                mem_din     = r_wdata;
                mem_wen     = r_wen & ~r_err;
                cs_lomem    = r_cs[2];
                cs_pmon     = r_cs[1];
                cs_himem    = r_cs[0];
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (r_gnt) begin
                    m1_ack   = 1'b1;
                    m1_err   = r_err;
                    m1_rdata = w_rd_ok ? mem_dout : '0;
                end else begin
                    m0_ack   = 1'b1;
                    m0_err   = r_err;
                    m0_rdata = w_rd_ok ? mem_dout : '0;
                end
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter with a memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_wen = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic        m1_req = 1'b0, m1_wen = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic [31:0] mem_dout = '0;

    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_din;
    logic        mem_wen, cs_lomem, cs_pmon, cs_himem;

    logic        n0_ack, n0_err, n1_ack, n1_err;
    logic [31:0] n0_rdata, n1_rdata, n_addr, n_din;
    logic        n_wen, n_cs_lo, n_cs_pm, n_cs_hi;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] lo_m [logic [31:0]];
    logic [31:0] pm_m [logic [31:0]];
    logic [31:0] hi_m [logic [31:0]];

    always #5 clk = ~clk;

    mem_arbiter u_dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen),
        .cs_lomem(cs_lomem), .cs_pmon(cs_pmon), .cs_himem(cs_himem),
        .mem_dout(mem_dout)
    );

    // Second instance without himem; shares all inputs.
    mem_arbiter #(.HIMEM_SIZE(0)) u_dut_nohi (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(n0_ack), .m0_rdata(n0_rdata), .m0_err(n0_err),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(n1_ack), .m1_rdata(n1_rdata), .m1_err(n1_err),
        .mem_addr(n_addr), .mem_din(n_din), .mem_wen(n_wen),
        .cs_lomem(n_cs_lo), .cs_pmon(n_cs_pm), .cs_himem(n_cs_hi),
        .mem_dout(mem_dout)
    );

    // Synchronous-read memory container model driven by the main instance.
    always @(posedge clk) begin
        if (cs_lomem) begin
            mem_dout <= lo_m.exists(mem_addr) ? lo_m[mem_addr] : 32'h0;
            if (mem_wen) lo_m[mem_addr] = mem_din;
        end else if (cs_pmon) begin
            mem_dout <= pm_m.exists(mem_addr - 32'h0000_F000) ? pm_m[mem_addr - 32'h0000_F000] : 32'h0;
            if (mem_wen) pm_m[mem_addr - 32'h0000_F000] = mem_din;
        end else if (cs_himem) begin
            mem_dout <= hi_m.exists(mem_addr - 32'h0001_0000) ? hi_m[mem_addr - 32'h0001_0000] : 32'h0;
            if (mem_wen) hi_m[mem_addr - 32'h0001_0000] = mem_din;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access from IDLE; exp_cs is {lomem, pmon, himem}.
    task automatic access(input int m, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd,
                          input logic exp_err, input logic [2:0] exp_cs);
        if (m == 0) begin
            m0_req = 1'b1; m0_wen = wen; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = 1'b1; m1_wen = wen; m1_addr = addr; m1_wdata = wdata;
        end
        tick();
        chk("issue_cs", {29'd0, cs_lomem, cs_pmon, cs_himem}, {29'd0, exp_cs});
        chk("issue_wen", {31'd0, mem_wen}, {31'd0, wen & ~exp_err});
        chk("issue_ack_low", {30'd0, m0_ack, m1_ack}, 32'd0);
        if (!exp_err) chk("issue_addr", mem_addr, addr);
        if (wen && !exp_err) chk("issue_din", mem_din, wdata);
        tick();
        chk("resp_ack", {30'd0, m0_ack, m1_ack}, (m == 0) ? 32'd2 : 32'd1);
        chk("resp_err", {31'd0, (m == 0) ? m0_err : m1_err}, {31'd0, exp_err});
        chk("resp_rdata", (m == 0) ? m0_rdata : m1_rdata, exp_rd);
        chk("resp_other_rdata", (m == 0) ? m1_rdata : m0_rdata, 32'd0);
        chk("resp_cs_low", {28'd0, cs_lomem, cs_pmon, cs_himem, mem_wen}, 32'd0);
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
    endtask

    initial begin
        pm_m[32'd4] = 32'h1234_5678;
        #3;
        chk("rst_outputs", {20'd0, m0_ack, m0_err, m1_ack, m1_err, mem_wen,
                            cs_lomem, cs_pmon, cs_himem, 4'd0}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        tick();
        reset = 1'b0;

        // Both masters requesting continuously: m0, m1, m0, m1 three cycles apart.
        m0_req = 1'b1; m0_wen = 1'b0; m0_addr = 32'h0000_0100;
        m1_req = 1'b1; m1_wen = 1'b0; m1_addr = 32'h0000_0200;
        for (int i = 1; i <= 11; i++) begin
            tick();
            chk($sformatf("rr_m0_ack_c%0d", i), {31'd0, m0_ack}, {31'd0, (i == 2 || i == 8)});
            chk($sformatf("rr_m1_ack_c%0d", i), {31'd0, m1_ack}, {31'd0, (i == 5 || i == 11)});
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();

        // lomem write then read-back.
        access(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 3'b100);
        access(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 3'b100);

        // pmon overrides lomem.
        access(1, 1'b0, 32'h0000_F004, 32'h0, 32'h1234_5678, 1'b0, 3'b010);

        // Himem present: last word round-trips, just past the end errors.
        access(0, 1'b1, 32'h0001_FFFF, 32'hA5A5_5A5A, 32'h0, 1'b0, 3'b001);
        access(0, 1'b0, 32'h0001_FFFF, 32'h0, 32'hA5A5_5A5A, 1'b0, 3'b001);
        access(1, 1'b0, 32'h0002_0000, 32'h0, 32'h0, 1'b1, 3'b000);

        // Himem absent instance: write and read of 0x1_0000 are unmapped.
        m0_req = 1'b1; m0_wen = 1'b1; m0_addr = 32'h0001_0000; m0_wdata = 32'h5555_AAAA;
        tick();
        chk("nohi_wr_bus", {27'd0, n_cs_lo, n_cs_pm, n_cs_hi, n_wen, 1'b0}, 32'd0);
        tick();
        chk("nohi_wr_ack", {30'd0, n0_ack, n0_err}, 32'd3);
        m0_req = 1'b0;
        tick();
        m0_req = 1'b1; m0_wen = 1'b0;
        tick();
        chk("nohi_rd_cs", {29'd0, n_cs_lo, n_cs_pm, n_cs_hi}, 32'd0);
        tick();
        chk("nohi_rd_ack", {30'd0, n0_ack, n0_err}, 32'd3);
        chk("nohi_rd_rdata", n0_rdata, 32'd0);
        m0_req = 1'b0;
        tick();

        // Reset during ISSUE of an m0 read.
        m0_req = 1'b1; m0_wen = 1'b0; m0_addr = 32'h0000_0010;
        tick();
        chk("preabort_cs", {31'd0, cs_lomem}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_bus", {27'd0, cs_lomem, cs_pmon, cs_himem, mem_wen, m0_ack}, 32'd0);
        chk("abort_addr", mem_addr, 32'd0);
        m0_req = 1'b0;
        tick();
        chk("abort_no_ack", {30'd0, m0_ack, m1_ack}, 32'd0);
        tick();
        chk("abort_no_ack2", {30'd0, m0_ack, m1_ack}, 32'd0);
        reset = 1'b0;
        access(1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 3'b100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
